// File: rtl/mips3_pkg.sv
// Shared encodings and pipeline types for the mips3 three-stage integer core.
package mips3_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // All-zero word decodes as SLL $0,$0,0, whose write is discarded.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } AluOp;

  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ} BrKind;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] storeData;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
  } ExWbReg;

  localparam ExWbReg EXWB_NOP = '0;

endpackage

// File: rtl/mips3_alu.sv
// Combinational integer ALU; shifts act on operand b, flags describe the result.
module mips3_alu
  import mips3_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  AluOp        op,
  output logic [31:0] result,
  output logic        zero,
  output logic        sign
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $signed(b) >>> shamt;
      ALU_LUI:  result = {b[15:0], 16'd0};
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'd0);
  assign sign = result[31];

endmodule

// File: rtl/mips3_core.sv
// MIPS-I integer core, IF/EX/WB pipeline with WB->EX forwarding and one delay slot.
// Define MULT_EN to add HI/LO and the multiply/move instructions.
module mips3_core
  import mips3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] InstrMem,
  output logic [15:0] InstrAddr,
  input  logic [31:0] MemData,
  output logic [31:0] WriteData,
  output logic [15:0] MemAddr,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [4:0]  RegAddr,
  output logic [31:0] RegData
);

  logic [15:0] pc, pcEx;
  logic [31:0] instrEx;
  ExWbReg      exWb;
  logic [31:0] gpr [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  assign opcode = instrEx[31:26];
  assign rs     = instrEx[25:21];
  assign rt     = instrEx[20:16];
  assign rd     = instrEx[15:11];
  assign shamt  = instrEx[10:6];
  assign funct  = instrEx[5:0];
  assign imm    = instrEx[15:0];

  // A load's value exists only as MemData during its WB cycle.
  logic [31:0] wbValue, rsVal, rtVal;
  assign wbValue = exWb.memRead ? MemData : exWb.result;
  assign rsVal = (rs != 5'd0 && exWb.regWrite && exWb.rd == rs) ? wbValue : gpr[rs];
  assign rtVal = (rt != 5'd0 && exWb.regWrite && exWb.rd == rt) ? wbValue : gpr[rt];

  logic [31:0] aluA, aluB, aluResult, exValue;
  logic [4:0]  aluShamt, wrReg;
  AluOp        aluOp;
  BrKind       brKind;
  logic        aluZero, aluSign, wrEn, memRd, memWr, link, jumpAbs, jumpReg;
  logic        redirect;
  logic [15:0] target;

`ifdef MULT_EN
  logic [31:0] hi, lo;
  logic [63:0] product;
  logic        mulWr, mulSigned, hiWr, loWr, selHi, selLo;
`endif

  always_comb begin
    aluA = rsVal; aluB = rtVal; aluShamt = shamt; aluOp = ALU_ADD; brKind = BR_NONE;
    wrEn = 1'b0; wrReg = rd; memRd = 1'b0; memWr = 1'b0;
    link = 1'b0; jumpAbs = 1'b0; jumpReg = 1'b0;
`ifdef MULT_EN
    mulWr = 1'b0; mulSigned = 1'b0; hiWr = 1'b0; loWr = 1'b0; selHi = 1'b0; selLo = 1'b0;
`endif
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_SLL:  begin aluOp = ALU_SLL; wrEn = 1'b1; end
          F_SRL:  begin aluOp = ALU_SRL; wrEn = 1'b1; end
          F_SRA:  begin aluOp = ALU_SRA; wrEn = 1'b1; end
          F_SLLV: begin aluOp = ALU_SLL; aluShamt = rsVal[4:0]; wrEn = 1'b1; end
          F_SRLV: begin aluOp = ALU_SRL; aluShamt = rsVal[4:0]; wrEn = 1'b1; end
          F_SRAV: begin aluOp = ALU_SRA; aluShamt = rsVal[4:0]; wrEn = 1'b1; end
          F_JR:   jumpReg = 1'b1;
          F_JALR: begin jumpReg = 1'b1; link = 1'b1; wrEn = 1'b1; end
          F_ADD, F_ADDU: begin aluOp = ALU_ADD; wrEn = 1'b1; end
          F_SUB, F_SUBU: begin aluOp = ALU_SUB; wrEn = 1'b1; end
          F_AND:  begin aluOp = ALU_AND;  wrEn = 1'b1; end
          F_OR:   begin aluOp = ALU_OR;   wrEn = 1'b1; end
          F_XOR:  begin aluOp = ALU_XOR;  wrEn = 1'b1; end
          F_NOR:  begin aluOp = ALU_NOR;  wrEn = 1'b1; end
          F_SLT:  begin aluOp = ALU_SLT;  wrEn = 1'b1; end
          F_SLTU: begin aluOp = ALU_SLTU; wrEn = 1'b1; end
`ifdef MULT_EN
          F_MFHI:  begin selHi = 1'b1; wrEn = 1'b1; end
          F_MFLO:  begin selLo = 1'b1; wrEn = 1'b1; end
          F_MTHI:  hiWr = 1'b1;
          F_MTLO:  loWr = 1'b1;
          F_MULT:  begin mulWr = 1'b1; mulSigned = 1'b1; end
          F_MULTU: mulWr = 1'b1;
`endif
          default: ;
        endcase
      end
      OP_J:    jumpAbs = 1'b1;
      OP_JAL:  begin jumpAbs = 1'b1; link = 1'b1; wrEn = 1'b1; wrReg = 5'd31; end
      OP_BEQ:  begin aluOp = ALU_SUB; brKind = BR_EQ; end
      OP_BNE:  begin aluOp = ALU_SUB; brKind = BR_NE; end
      OP_BLEZ: begin aluOp = ALU_SUB; aluB = '0; brKind = BR_LEZ; end
      OP_BGTZ: begin aluOp = ALU_SUB; aluB = '0; brKind = BR_GTZ; end
      OP_ADDI, OP_ADDIU: begin aluB = {{16{imm[15]}}, imm}; wrEn = 1'b1; wrReg = rt; end
      OP_SLTI:  begin aluOp = ALU_SLT;  aluB = {{16{imm[15]}}, imm}; wrEn = 1'b1; wrReg = rt; end
      OP_SLTIU: begin aluOp = ALU_SLTU; aluB = {{16{imm[15]}}, imm}; wrEn = 1'b1; wrReg = rt; end
      OP_ANDI: begin aluOp = ALU_AND; aluB = {16'd0, imm}; wrEn = 1'b1; wrReg = rt; end
      OP_ORI:  begin aluOp = ALU_OR;  aluB = {16'd0, imm}; wrEn = 1'b1; wrReg = rt; end
      OP_XORI: begin aluOp = ALU_XOR; aluB = {16'd0, imm}; wrEn = 1'b1; wrReg = rt; end
      OP_LUI:  begin aluOp = ALU_LUI; aluB = {16'd0, imm}; wrEn = 1'b1; wrReg = rt; end
      OP_LW:   begin aluB = {{16{imm[15]}}, imm}; memRd = 1'b1; wrEn = 1'b1; wrReg = rt; end
      OP_SW:   begin aluB = {{16{imm[15]}}, imm}; memWr = 1'b1; end
      default: ;
    endcase
  end

  mips3_alu uAlu (
    .a(aluA), .b(aluB), .shamt(aluShamt), .op(aluOp),
    .result(aluResult), .zero(aluZero), .sign(aluSign)
  );

  // The delay-slot instruction is already being fetched, so a redirect only reloads PC.
  always_comb begin
    redirect = 1'b0;
    target   = pcEx + 16'd4 + {imm[13:0], 2'b00};
    case (brKind)
      BR_EQ:   redirect = aluZero;
      BR_NE:   redirect = !aluZero;
      BR_LEZ:  redirect = aluSign || aluZero;
      BR_GTZ:  redirect = !aluSign && !aluZero;
      default: redirect = 1'b0;
    endcase
    if (jumpAbs) begin
      redirect = 1'b1;
      target   = {instrEx[13:0], 2'b00};
    end
    if (jumpReg) begin
      redirect = 1'b1;
      target   = {rsVal[15:2], 2'b00};
    end
  end

  always_comb begin
    exValue = link ? {16'd0, pcEx + 16'd8} : aluResult;
`ifdef MULT_EN
    if (selHi) exValue = hi;
    if (selLo) exValue = lo;
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc      <= RESET_PC;
      pcEx    <= RESET_PC;
      instrEx <= NOP_INSTR;
      exWb    <= EXWB_NOP;
      RegData <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      pc      <= redirect ? target : pc + 16'd4;
      pcEx    <= pc;
      instrEx <= InstrMem;
      exWb    <= '{result: exValue, storeData: rtVal, rd: wrReg,
                   regWrite: wrEn, memRead: memRd, memWrite: memWr};
      if (exWb.regWrite && exWb.rd != 5'd0) gpr[exWb.rd] <= wbValue;
      RegData <= gpr[RegAddr];
    end
  end

`ifdef MULT_EN
  always_comb begin
    if (mulSigned) product = $signed({{32{rsVal[31]}}, rsVal}) * $signed({{32{rtVal[31]}}, rtVal});
    else           product = {32'd0, rsVal} * {32'd0, rtVal};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hi <= '0;
      lo <= '0;
    end else if (mulWr) begin
      hi <= product[63:32];
      lo <= product[31:0];
    end else begin
      if (hiWr) hi <= rsVal;
      if (loWr) lo <= rsVal;
    end
  end
`endif

  assign InstrAddr = pc;
  assign MemAddr   = exWb.result[15:0];
  assign MemRead   = exWb.memRead;
  assign MemWrite  = exWb.memWrite;
  assign WriteData = exWb.storeData;

endmodule

// File: tb/tb_mips3_core.sv
// Directed bench for mips3_core: small programs with hand-computed register, bus and fetch results.
module tb_mips3_core;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] InstrMem, MemData, WriteData, RegData;
  logic [15:0] InstrAddr, MemAddr;
  logic        MemWrite, MemRead;
  logic [4:0]  RegAddr;

  logic [31:0] imem [256];
  logic [31:0] dmem [16];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];
  logic [4:0]  addr_q [$];

  mips3_core #(.RESET_PC(16'h0000)) dut (
    .Clock(Clock), .Reset(Reset), .InstrMem(InstrMem), .InstrAddr(InstrAddr),
    .MemData(MemData), .WriteData(WriteData), .MemAddr(MemAddr),
    .MemWrite(MemWrite), .MemRead(MemRead), .RegAddr(RegAddr), .RegData(RegData)
  );

  // Clock and memories
  always #5 Clock = ~Clock;
  assign InstrMem = imem[InstrAddr[9:2]];
  assign MemData  = dmem[MemAddr[5:2]];
  always @(posedge Clock) if (MemWrite) dmem[MemAddr[5:2]] <= WriteData;

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] jType(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Driver tasks; every task begins and ends on a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic clearImem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectReg(input logic [4:0] a, input logic [31:0] v);
    addr_q.push_back(a);
    exp_q.push_back(v);
  endtask

  // Scoreboard: read each queued register through the debug port.
  task automatic drainRegs(input string tag);
    logic [4:0]  a;
    logic [31:0] e;
    while (addr_q.size() > 0) begin
      a = addr_q.pop_front();
      e = exp_q.pop_front();
      RegAddr = a;
      tick(1);
      check($sformatf("%s r%0d", tag, a), RegData, e);
    end
  endtask

  logic [15:0] trace [14];

  initial begin
    Reset   = 1'b1;
    RegAddr = 5'd0;
    clearImem();
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;

    // Reset held five cycles
    tick(1);
    check("reset InstrAddr", {16'h0, InstrAddr}, 32'h0);
    check("reset MemRead",   {31'h0, MemRead},   32'h0);
    check("reset MemWrite",  {31'h0, MemWrite},  32'h0);
    check("reset RegData",   RegData,            32'h0);
    tick(4);
    Reset = 1'b0;
    check("fetch0", {16'h0, InstrAddr}, 32'h0);
    tick(1);
    check("fetch1", {16'h0, InstrAddr}, 32'h4);
    tick(1);
    check("fetch2", {16'h0, InstrAddr}, 32'h8);
    check("idle MemRead",  {31'h0, MemRead},  32'h0);
    check("idle MemWrite", {31'h0, MemWrite}, 32'h0);
    for (int r = 0; r < 32; r++) expectReg(5'(r), 32'h0);
    drainRegs("after reset");

    // Program 1: forwarding, compares, store/load, LUI, $0, SRA
    Reset = 1'b1;
    clearImem();
    imem[0]  = iType(6'h09, 5'd0, 5'd1, 16'd5);
    imem[1]  = iType(6'h09, 5'd1, 5'd2, 16'd3);
    imem[2]  = iType(6'h09, 5'd0, 5'd3, 16'hFFFF);
    imem[3]  = rType(5'd0, 5'd3, 5'd4, 5'd0, 6'h2B);
    imem[4]  = rType(5'd0, 5'd3, 5'd5, 5'd0, 6'h2A);
    imem[5]  = iType(6'h09, 5'd0, 5'd1, 16'h1234);
    imem[6]  = iType(6'h2B, 5'd0, 5'd1, 16'd8);
    imem[7]  = iType(6'h23, 5'd0, 5'd6, 16'd8);
    imem[8]  = rType(5'd6, 5'd6, 5'd7, 5'd0, 6'h21);
    imem[9]  = iType(6'h0F, 5'd0, 5'd8, 16'hABCD);
    imem[10] = iType(6'h09, 5'd0, 5'd0, 16'd7);
    imem[11] = iType(6'h0F, 5'd0, 5'd9, 16'h8000);
    imem[12] = rType(5'd0, 5'd9, 5'd10, 5'd4, 6'h03);
    imem[13] = jType(6'h02, 26'h00000D);
    tick(2);
    Reset = 1'b0;
    check("p1 start", {16'h0, InstrAddr}, 32'h0);
    tick(8);
    check("sw MemWrite",  {31'h0, MemWrite}, 32'h1);
    check("sw MemRead",   {31'h0, MemRead},  32'h0);
    check("sw MemAddr",   {16'h0, MemAddr},  32'h8);
    check("sw WriteData", WriteData,         32'h0000_1234);
    tick(1);
    check("lw MemRead",  {31'h0, MemRead},  32'h1);
    check("lw MemWrite", {31'h0, MemWrite}, 32'h0);
    check("lw MemAddr",  {16'h0, MemAddr},  32'h8);
    tick(10);
    expectReg(5'd1,  32'h0000_1234);
    expectReg(5'd2,  32'h0000_0008);
    expectReg(5'd3,  32'hFFFF_FFFF);
    expectReg(5'd4,  32'h0000_0001);
    expectReg(5'd5,  32'h0000_0000);
    expectReg(5'd6,  32'h0000_1234);
    expectReg(5'd7,  32'h0000_2468);
    expectReg(5'd8,  32'hABCD_0000);
    expectReg(5'd0,  32'h0000_0000);
    expectReg(5'd10, 32'hF800_0000);
    drainRegs("p1");

    // Program 2: branch with delay slot, JAL/JR
    Reset = 1'b1;
    clearImem();
    imem[0]  = iType(6'h09, 5'd0, 5'd1, 16'd1);
    imem[4]  = iType(6'h04, 5'd0, 5'd0, 16'd2);
    imem[5]  = iType(6'h09, 5'd0, 5'd2, 16'h0014);
    imem[6]  = iType(6'h09, 5'd0, 5'd3, 16'h0018);
    imem[7]  = iType(6'h05, 5'd0, 5'd0, 16'd5);
    imem[8]  = jType(6'h03, 26'h000010);
    imem[9]  = iType(6'h09, 5'd0, 5'd4, 16'h0024);
    imem[10] = iType(6'h09, 5'd0, 5'd5, 16'h0028);
    imem[11] = jType(6'h02, 26'h00000B);
    imem[16] = rType(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    imem[17] = iType(6'h09, 5'd0, 5'd6, 16'h0044);
    imem[18] = iType(6'h09, 5'd0, 5'd7, 16'h0048);
    trace = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h1C,
              16'h20, 16'h24, 16'h40, 16'h44, 16'h28, 16'h2C, 16'h30};
    tick(2);
    Reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      check($sformatf("p2 fetch%0d", k), {16'h0, InstrAddr}, {16'h0, trace[k]});
      tick(1);
    end
    tick(6);
    expectReg(5'd1,  32'h1);
    expectReg(5'd2,  32'h14);
    expectReg(5'd3,  32'h0);
    expectReg(5'd4,  32'h24);
    expectReg(5'd5,  32'h28);
    expectReg(5'd6,  32'h44);
    expectReg(5'd7,  32'h0);
    expectReg(5'd31, 32'h28);
    drainRegs("p2");

    // Reset while JAL is in EX: nothing in flight may complete
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(8);
    Reset = 1'b1;
    #1;
    check("midreset InstrAddr", {16'h0, InstrAddr}, 32'h0);
    check("midreset MemWrite",  {31'h0, MemWrite},  32'h0);
    check("midreset MemRead",   {31'h0, MemRead},   32'h0);
    check("midreset MemAddr",   {16'h0, MemAddr},   32'h0);
    check("midreset RegData",   RegData,            32'h0);
    clearImem();
    tick(2);
    Reset = 1'b0;
    tick(1);
    check("post reset fetch1", {16'h0, InstrAddr}, 32'h4);
    expectReg(5'd1,  32'h0);
    expectReg(5'd2,  32'h0);
    expectReg(5'd4,  32'h0);
    expectReg(5'd31, 32'h0);
    drainRegs("midreset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
